// File: rtl/cdb_arbiter_if.sv
// Result-payload types shared by the FU wrappers and CDB listeners, plus the
// bundle of FU-result and CDB broadcast signals around cdb_arbiter.
package cdb_pkg;

  typedef struct packed {
    logic [3:0] rob_id;
    logic [4:0] rd_addr;
    logic       rd_we;
  } inst_info_t;

  typedef struct packed {
    logic [31:0] pc_rdata;
    logic [31:0] insn;
  } rvfi_t;

  typedef struct packed {
    logic        ready_for_writeback;
    inst_info_t  inst_info;
    logic [31:0] register_value;
    rvfi_t       rvfi;
  } fu_output_t;

endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4
);
  cdb_pkg::fu_output_t fu_out [NUM_FU];
  logic [NUM_FU-1:0]   fu_full;
  logic                flush;
  cdb_pkg::fu_output_t cdb;
  logic                cdb_valid;
  logic                overflow_err;

  // master: FU wrappers / pipeline control side; slave: the arbiter
  modport master (
    output fu_out, flush,
    input  fu_full, cdb, cdb_valid, overflow_err
  );

  modport slave (
    input  fu_out, flush,
    output fu_full, cdb, cdb_valid, overflow_err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Buffers results from NUM_FU functional units in small per-FU FIFOs and
// broadcasts at most one per cycle on the CDB, round-robin across FUs.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU      = 4,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int RW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int SW = RW + 1;
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [NUM_FU-1:0] presented;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] accept;
  logic [NUM_FU-1:0] from_queue;
  logic [NUM_FU-1:0] has_cand;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  fu_output_t        cand [NUM_FU];

  logic              grant;
  logic [RW-1:0]     win;
  logic [RW-1:0]     rr;
  logic              overflow_hit;

  fu_output_t        cdb_reg;
  logic              cdb_valid_reg;
  logic              overflow_reg;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QUEUE_DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    logic [CW-1:0] cnt;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    fu_output_t    mem [QUEUE_DEPTH];
    logic          is_win;

    // Full is a function of the count alone, so a pop this cycle never
    // makes room for an arrival in the same cycle.
    assign presented[gi]  = bus.fu_out[gi].ready_for_writeback;
    assign full[gi]       = (cnt == CW'(QUEUE_DEPTH));
    assign accept[gi]     = presented[gi] && !full[gi];
    assign from_queue[gi] = (cnt != '0);
    assign has_cand[gi]   = from_queue[gi] || accept[gi];
    assign cand[gi]       = from_queue[gi] ? mem[head] : bus.fu_out[gi];

    assign is_win   = grant && (win == RW'(gi));
    assign pop[gi]  = is_win && from_queue[gi];
    assign push[gi] = accept[gi] && !(is_win && !from_queue[gi]);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt  <= '0;
        head <= '0;
        tail <= '0;
      end else if (bus.flush) begin
        cnt  <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (push[gi]) tail <= ptr_inc(tail);
        if (pop[gi])  head <= ptr_inc(head);
        if (push[gi] && !pop[gi])      cnt <= cnt + CW'(1);
        else if (pop[gi] && !push[gi]) cnt <= cnt - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push[gi] && !bus.flush) mem[tail] <= bus.fu_out[gi];
    end
  end

  // Rotating priority search starting at rr; first FU with a candidate wins.
  always_comb begin
    logic [SW-1:0] sum;
    logic [RW-1:0] idx;
    grant = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr} + SW'(k);
      if (sum >= SW'(NUM_FU)) sum = sum - SW'(NUM_FU);
      idx = sum[RW-1:0];
      if (!grant && has_cand[idx]) begin
        grant = 1'b1;
        win   = idx;
      end
    end
  end

  assign overflow_hit = |(presented & full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr            <= '0;
      cdb_reg       <= '0;
      cdb_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      rr            <= '0;
      cdb_reg       <= '0;
      cdb_valid_reg <= 1'b0;
    end else if (grant) begin
      cdb_reg       <= cand[win];
      cdb_valid_reg <= 1'b1;
      rr            <= (win == RW'(NUM_FU - 1)) ? '0 : win + RW'(1);
    end else begin
      cdb_reg       <= '0;
      cdb_valid_reg <= 1'b0;
    end
  end

  // Sticky protocol-violation flag; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              overflow_reg <= 1'b0;
    else if (overflow_hit) overflow_reg <= 1'b1;
  end

  assign bus.fu_full      = full;
  assign bus.cdb          = cdb_reg;
  assign bus.cdb_valid    = cdb_valid_reg;
  assign bus.overflow_err = overflow_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized + directed bench for cdb_arbiter; a queue-based reference model
// feeds a scoreboard that a separate monitor drains on every CDB broadcast.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NF = 4;
  localparam int QD = 2;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.NUM_FU(NF)) bus ();

  cdb_arbiter #(.NUM_FU(NF), .QUEUE_DEPTH(QD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one plain queue per FU, a round-robin start index,
  // and the sticky overflow flag.
  fu_output_t  mq [NF][$];
  fu_output_t  exp_q [$];
  int          m_rr  = 0;
  logic        m_ovf = 1'b0;
  logic [31:0] vals [NF];
  fu_output_t  drv [NF];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic chk_pl(input string name, input fu_output_t act, input fu_output_t want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  function automatic fu_output_t mk(input logic [31:0] v);
    fu_output_t p;
    p.ready_for_writeback    = 1'b1;
    p.inst_info.rob_id       = 4'($urandom);
    p.inst_info.rd_addr      = 5'($urandom);
    p.inst_info.rd_we        = 1'($urandom);
    p.register_value         = v;
    p.rvfi.pc_rdata          = $urandom;
    p.rvfi.insn              = $urandom;
    return p;
  endfunction

  function automatic int occ();
    int n = 0;
    for (int i = 0; i < NF; i++) n += mq[i].size();
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) mq[i].delete();
    exp_q.delete();
    m_rr  = 0;
    m_ovf = 1'b0;
  endtask

  // One clock edge of the reference behaviour: arrivals join their FU queue
  // unless it was already full, then the first non-empty queue from m_rr
  // hands its oldest result to the CDB.
  task automatic model_edge(input logic [NF-1:0] pres, input logic fl);
    bit found = 0;
    for (int i = 0; i < NF; i++)
      if (pres[i] && mq[i].size() == QD) m_ovf = 1'b1;
    if (fl) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      m_rr = 0;
      return;
    end
    for (int i = 0; i < NF; i++)
      if (pres[i] && mq[i].size() < QD) mq[i].push_back(drv[i]);
    for (int k = 0; k < NF; k++) begin
      int idx = (m_rr + k) % NF;
      if (!found && mq[idx].size() > 0) begin
        exp_q.push_back(mq[idx].pop_front());
        m_rr  = (idx + 1) % NF;
        found = 1;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [NF-1:0] pres, input logic fl);
    logic [NF-1:0] ef;
    for (int i = 0; i < NF; i++) ef[i] = (mq[i].size() == QD);
    chk("fu_full", 32'(bus.fu_full), 32'(ef));
    chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
    for (int i = 0; i < NF; i++) begin
      drv[i] = pres[i] ? mk(vals[i]) : '0;
      bus.fu_out[i] = drv[i];
    end
    bus.flush = fl;
    @(posedge clk);
    model_edge(pres, fl);
    @(negedge clk);
    for (int i = 0; i < NF; i++) bus.fu_out[i] = '0;
    bus.flush = 1'b0;
  endtask

  task automatic set_vals(input logic [31:0] base);
    for (int i = 0; i < NF; i++) vals[i] = base + 32'(i);
  endtask

  // Monitor: every broadcast must match the oldest expected result.
  initial begin
    fu_output_t e;
    forever begin
      @(negedge clk);
      if (bus.cdb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cdb_unexpected got=%h want=no broadcast", bus.cdb);
        end else begin
          e = exp_q.pop_front();
          chk_pl("cdb_payload", bus.cdb, e);
        end
      end else begin
        chk_pl("cdb_idle_zero", bus.cdb, '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NF-1:0] pres;
    int f2_sent;
    int f2_seen;

    rst       = 1'b0;
    bus.flush = 1'b0;
    for (int i = 0; i < NF; i++) begin
      bus.fu_out[i] = '0;
      vals[i]       = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_fu_full", 32'(bus.fu_full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow_err), 32'd0);
    rst = 1'b1;

    // Single result in an idle system, one-cycle latency
    set_vals(32'h0);
    repeat (3) step('0, 1'b0);
    vals[1] = 32'h0000_0006;
    step(4'b0010, 1'b0);
    chk("single_valid", 32'(bus.cdb_valid), 32'd1);
    chk("single_value", bus.cdb.register_value, 32'h6);
    step('0, 1'b0);
    chk("single_idle", 32'(bus.cdb_valid), 32'd0);

    // Simultaneous arrivals from rr = 0
    step('0, 1'b1);
    set_vals(32'hA0);
    step(4'b1111, 1'b0);
    for (int k = 0; k < NF; k++) begin
      chk("simul_valid", 32'(bus.cdb_valid), 32'd1);
      chk("simul_value", bus.cdb.register_value, 32'hA0 + 32'(k));
      if (k < NF - 1) step('0, 1'b0);
    end
    step('0, 1'b0);
    chk("simul_drained", 32'(bus.cdb_valid), 32'd0);

    // Fairness: FU0 streams while FU2 presents once
    f2_sent = -1;
    f2_seen = -1;
    for (int c = 0; c < 10; c++) begin
      pres = '0;
      vals[0] = 32'h0F00_0000 + 32'(c);
      if (mq[0].size() < QD) pres[0] = 1'b1;
      if (c == 2) begin
        pres[2] = 1'b1;
        vals[2] = 32'hF2F2_0002;
        f2_sent = c;
      end
      step(pres, 1'b0);
      if (f2_seen < 0 && bus.cdb_valid === 1'b1 && bus.cdb.register_value == 32'hF2F2_0002)
        f2_seen = c;
    end
    chk("fair_fu2_within_2", 32'(f2_seen >= 0 && (f2_seen - f2_sent) <= 1), 32'd1);

    // Full and overflow on FU3
    step('0, 1'b1);
    set_vals(32'hB0);
    step(4'b1111, 1'b0);
    set_vals(32'hC0);
    step(4'b1111, 1'b0);
    chk("ovf_full3", 32'(bus.fu_full[3]), 32'd1);
    vals[3] = 32'hD3;
    step(4'b1000, 1'b0);
    chk("ovf_set", 32'(bus.overflow_err), 32'd1);
    repeat (6) step('0, 1'b0);
    step('0, 1'b1);
    chk("ovf_sticky_flush", 32'(bus.overflow_err), 32'd1);

    // Flush with three results buffered and a new FU1 arrival
    set_vals(32'hE0);
    step(4'b1111, 1'b0);
    chk("flush_pre_occ", 32'(occ()), 32'd3);
    vals[1] = 32'hE1E1;
    step(4'b0010, 1'b1);
    chk("flush_valid", 32'(bus.cdb_valid), 32'd0);
    chk("flush_fu_full", 32'(bus.fu_full), 32'd0);
    repeat (3) begin
      step('0, 1'b0);
      chk("flush_quiet", 32'(bus.cdb_valid), 32'd0);
    end

    // Asynchronous reset mid-burst
    set_vals(32'h50);
    step(4'b1111, 1'b0);
    chk("arst_pre_valid", 32'(bus.cdb_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.cdb_valid), 32'd0);
    chk_pl("arst_cdb", bus.cdb, '0);
    chk("arst_fu_full", 32'(bus.fu_full), 32'd0);
    chk("arst_overflow", 32'(bus.overflow_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    vals[2] = 32'h7777;
    step(4'b0100, 1'b0);
    chk("arst_after_valid", 32'(bus.cdb_valid), 32'd1);
    chk("arst_after_value", bus.cdb.register_value, 32'h7777);

    // Randomized traffic that honours fu_full
    for (int c = 0; c < 400; c++) begin
      pres = '0;
      for (int i = 0; i < NF; i++) begin
        vals[i] = $urandom;
        if (mq[i].size() < QD && $urandom_range(0, 99) < 55) pres[i] = 1'b1;
      end
      step(pres, ($urandom_range(0, 39) == 0));
    end

    for (int n = 0; n < 40 && occ() > 0; n++) step('0, 1'b0);
    chk("drain_model_empty", 32'(occ()), 32'd0);
    step('0, 1'b0);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
